// File: rtl/branch_predictor_bht.sv
// Branch history table of saturating counters with optional gshare indexing,
// a non-speculative global history register and saturating perf counters.
module branch_predictor_bht #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int GSHARE  = 0,
  parameter int HIST_W  = 4,
  parameter int PERF_W  = 32,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_branch,
  input  logic [31:0]       dec_pc,
  input  logic [31:0]       dec_offset,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic [IDX_W-1:0]  pred_index,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic              upd_taken,
  input  logic              upd_predicted,
  output logic              mispredict,
  output logic [PERF_W-1:0] perf_lookups,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  // Weakly-not-taken: MSB clear, all lower bits set (0 when CTR_W = 1).
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [CTR_W-1:0]  ctr_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_d [ENTRIES];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [PERF_W-1:0] lookups_q, lookups_d;
  logic [PERF_W-1:0] mispred_q, mispred_d;
  logic [IDX_W-1:0]  base_idx;
  logic [IDX_W-1:0]  ghr_ext;

  // Lookup reads pre-edge table and history; updates land one edge later.
  always_comb begin
    base_idx = dec_pc[IDX_W+1:2];
    ghr_ext = '0;
    ghr_ext[HIST_W-1:0] = ghr_q;
    pred_index = (GSHARE != 0) ? (base_idx ^ ghr_ext) : base_idx;
    pred_taken = dec_branch & ctr_q[pred_index][CTR_W-1];
    pred_target = dec_pc + dec_offset;
    mispredict = upd_valid & (upd_taken != upd_predicted);
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ctr_d[i] = ctr_q[i];
    end
    ghr_d = ghr_q;
    if (upd_valid) begin
      if (upd_taken && (ctr_q[upd_index] != CTR_MAX)) begin
        ctr_d[upd_index] = ctr_q[upd_index] + 1'b1;
      end else if (!upd_taken && (ctr_q[upd_index] != '0)) begin
        ctr_d[upd_index] = ctr_q[upd_index] - 1'b1;
      end
      ghr_d = HIST_W'({ghr_q, upd_taken});
    end

    lookups_d = lookups_q;
    if (dec_branch && (lookups_q != {PERF_W{1'b1}})) begin
      lookups_d = lookups_q + 1'b1;
    end
    mispred_d = mispred_q;
    if (mispredict && (mispred_q != {PERF_W{1'b1}})) begin
      mispred_d = mispred_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RST;
      end
      ghr_q     <= '0;
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
      ghr_q     <= ghr_d;
      lookups_q <= lookups_d;
      mispred_q <= mispred_d;
    end
  end

  assign perf_lookups = lookups_q;
  assign perf_mispred = mispred_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench: a bimodal instance driven from a vector table and a small
// gshare instance (2-bit perf counters) driven by hand-written sequences.
module tb_branch_predictor_bht;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, dec_branch, pred_taken, upd_valid, upd_taken, upd_predicted, mispredict;
  logic [31:0] dec_pc, dec_offset, pred_target, perf_lookups, perf_mispred;
  logic [3:0]  pred_index, upd_index;

  logic        g_reset, g_dec_branch, g_pred_taken, g_upd_valid, g_upd_taken, g_upd_predicted, g_mispredict;
  logic [31:0] g_dec_pc, g_dec_offset, g_pred_target;
  logic [3:0]  g_pred_index, g_upd_index;
  logic [1:0]  g_perf_lookups, g_perf_mispred;

  branch_predictor_bht dut (
    .clk(clk), .reset(reset), .dec_branch(dec_branch), .dec_pc(dec_pc),
    .dec_offset(dec_offset), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_index(pred_index), .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_taken(upd_taken), .upd_predicted(upd_predicted), .mispredict(mispredict),
    .perf_lookups(perf_lookups), .perf_mispred(perf_mispred)
  );

  branch_predictor_bht #(
    .ENTRIES(16), .CTR_W(2), .GSHARE(1), .HIST_W(4), .PERF_W(2)
  ) gdut (
    .clk(clk), .reset(g_reset), .dec_branch(g_dec_branch), .dec_pc(g_dec_pc),
    .dec_offset(g_dec_offset), .pred_taken(g_pred_taken), .pred_target(g_pred_target),
    .pred_index(g_pred_index), .upd_valid(g_upd_valid), .upd_index(g_upd_index),
    .upd_taken(g_upd_taken), .upd_predicted(g_upd_predicted), .mispredict(g_mispredict),
    .perf_lookups(g_perf_lookups), .perf_mispred(g_perf_mispred)
  );

  typedef struct {
    logic        uv;
    logic [3:0]  ui;
    logic        ut;
    logic        up;
    logic        db;
    logic [31:0] pc;
    logic [31:0] off;
    logic        e_taken;
    logic [3:0]  e_idx;
    logic [31:0] e_tgt;
    logic        e_mis;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];
  int n_checks;
  int n_errors;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_main();
    dec_branch = 1'b0; dec_pc = 32'h0; dec_offset = 32'h0;
    upd_valid = 1'b0; upd_index = 4'h0; upd_taken = 1'b0; upd_predicted = 1'b0;
  endtask

  task automatic idle_g();
    g_dec_branch = 1'b0; g_dec_pc = 32'h0; g_dec_offset = 32'h0;
    g_upd_valid = 1'b0; g_upd_index = 4'h0; g_upd_taken = 1'b0; g_upd_predicted = 1'b0;
  endtask

  initial begin
    int exp_lk;
    int exp_mp;
    logic outs [4];
    n_checks = 0;
    n_errors = 0;

    //          uv    ui    ut    up    db    pc            off           et    ei     tgt           em
    vecs[0]  = '{1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 32'h14,       32'h10,       1'b0, 4'd5,  32'h24,       1'b1};
    vecs[1]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 32'h14,       32'hFFFFFFFC, 1'b1, 4'd5,  32'h10,       1'b0};
    vecs[2]  = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 32'hC,        32'h0,        1'b0, 4'd3,  32'hC,        1'b1};
    vecs[3]  = '{1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 32'hC,        32'h0,        1'b1, 4'd3,  32'hC,        1'b0};
    vecs[4]  = '{1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 32'hC,        32'h0,        1'b1, 4'd3,  32'hC,        1'b0};
    vecs[5]  = '{1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 32'hC,        32'h0,        1'b1, 4'd3,  32'hC,        1'b0};
    vecs[6]  = '{1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 32'hC,        32'h0,        1'b1, 4'd3,  32'hC,        1'b1};
    vecs[7]  = '{1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 32'hC,        32'h0,        1'b1, 4'd3,  32'hC,        1'b1};
    vecs[8]  = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 32'hC,        32'h0,        1'b0, 4'd3,  32'hC,        1'b0};
    vecs[9]  = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 32'hC,        32'h0,        1'b0, 4'd3,  32'hC,        1'b0};
    vecs[10] = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 32'hC,        32'h0,        1'b0, 4'd3,  32'hC,        1'b1};
    vecs[11] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 32'hC,        32'h0,        1'b0, 4'd3,  32'hC,        1'b0};
    vecs[12] = '{1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 32'h8,        32'h0,        1'b0, 4'd2,  32'h8,        1'b1};
    vecs[13] = '{1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 32'h8,        32'h0,        1'b1, 4'd2,  32'h8,        1'b0};
    vecs[14] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h8,        1'b0, 4'd15, 32'h4,        1'b0};
    vecs[15] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h14,       32'h0,        1'b0, 4'd5,  32'h14,       1'b0};

    idle_main();
    idle_g();
    reset = 1'b1;
    g_reset = 1'b1;
    tick();
    reset = 1'b0;
    g_reset = 1'b0;

    @(negedge clk);
    chk("rst_lookups", perf_lookups, 32'd0);
    chk("rst_mispred", perf_mispred, 32'd0);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_pred_nobranch", {31'd0, pred_taken}, 32'd0);
    tick();

    // Every entry must read weakly-not-taken after reset.
    for (int i = 0; i < 16; i++) begin
      dec_branch = 1'b1;
      dec_pc = 32'(i) << 2;
      @(negedge clk);
      chk("rst_sweep_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_sweep_index", {28'd0, pred_index}, 32'(i));
      tick();
    end
    idle_main();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    exp_lk = 0;
    exp_mp = 0;
    for (int v = 0; v < NVEC; v++) begin
      upd_valid = vecs[v].uv; upd_index = vecs[v].ui;
      upd_taken = vecs[v].ut; upd_predicted = vecs[v].up;
      dec_branch = vecs[v].db; dec_pc = vecs[v].pc; dec_offset = vecs[v].off;
      if (vecs[v].db) exp_lk++;
      if (vecs[v].e_mis) exp_mp++;
      @(negedge clk);
      $display("vec %0d: pc=%h idx=%0d taken=%b tgt=%h mis=%b", v, dec_pc, pred_index,
               pred_taken, pred_target, mispredict);
      chk($sformatf("vec%0d_taken", v), {31'd0, pred_taken}, {31'd0, vecs[v].e_taken});
      chk($sformatf("vec%0d_index", v), {28'd0, pred_index}, {28'd0, vecs[v].e_idx});
      chk($sformatf("vec%0d_target", v), pred_target, vecs[v].e_tgt);
      chk($sformatf("vec%0d_mispredict", v), {31'd0, mispredict}, {31'd0, vecs[v].e_mis});
      tick();
    end
    idle_main();
    @(negedge clk);
    chk("table_lookups", perf_lookups, 32'(exp_lk));
    chk("table_mispred", perf_mispred, 32'(exp_mp));
    $display("table done: lookups=%0d mispred=%0d", perf_lookups, perf_mispred);

    // Perf counting, then reset colliding with an update and a lookup.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dec_branch = 1'b1; dec_pc = 32'h0;
    upd_valid = 1'b1; upd_index = 4'd1; upd_taken = 1'b1; upd_predicted = 1'b0;
    tick();
    tick();
    upd_valid = 1'b0;
    dec_pc = 32'h4;
    @(negedge clk);
    chk("perf_seq_idx1_taken", {31'd0, pred_taken}, 32'd1);
    tick();
    idle_main();
    @(negedge clk);
    chk("perf_seq_lookups", perf_lookups, 32'd3);
    chk("perf_seq_mispred", perf_mispred, 32'd2);
    $display("perf seq: lookups=%0d mispred=%0d", perf_lookups, perf_mispred);
    reset = 1'b1;
    dec_branch = 1'b1;
    upd_valid = 1'b1; upd_index = 4'd0; upd_taken = 1'b1; upd_predicted = 1'b0;
    tick();
    reset = 1'b0;
    idle_main();
    @(negedge clk);
    chk("midrst_lookups", perf_lookups, 32'd0);
    chk("midrst_mispred", perf_mispred, 32'd0);
    dec_branch = 1'b1; dec_pc = 32'h0;
    #1;
    chk("midrst_idx0_taken", {31'd0, pred_taken}, 32'd0);
    dec_pc = 32'h4;
    #1;
    chk("midrst_idx1_taken", {31'd0, pred_taken}, 32'd0);
    tick();
    idle_main();

    // Gshare: outcomes 1,0,1,1 to index 0, always mispredicted.
    outs = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      g_upd_valid = 1'b1; g_upd_index = 4'd0;
      g_upd_taken = outs[k]; g_upd_predicted = ~outs[k];
      if (k == 3) begin
        g_dec_branch = 1'b1;
        g_dec_pc = 32'h10;
        @(negedge clk);
        chk("gs_preedge_index", {28'd0, g_pred_index}, 32'd1);
        chk("gs_mispredict", {31'd0, g_mispredict}, 32'd1);
      end
      $display("gshare update %0d: taken=%b", k, outs[k]);
      tick();
    end
    g_upd_valid = 1'b0;
    g_dec_branch = 1'b1; g_dec_pc = 32'h10; g_dec_offset = 32'h20;
    @(negedge clk);
    chk("gs_index", {28'd0, g_pred_index}, 32'd15);
    chk("gs_taken15", {31'd0, g_pred_taken}, 32'd0);
    chk("gs_target", g_pred_target, 32'h30);
    tick();
    g_dec_pc = 32'h2C;
    @(negedge clk);
    chk("gs_index0", {28'd0, g_pred_index}, 32'd0);
    chk("gs_taken0", {31'd0, g_pred_taken}, 32'd1);
    tick();
    tick();
    idle_g();
    @(negedge clk);
    chk("gs_lookups_sat", {30'd0, g_perf_lookups}, 32'd3);
    chk("gs_mispred_sat", {30'd0, g_perf_mispred}, 32'd3);
    g_reset = 1'b1;
    g_dec_branch = 1'b1;
    g_upd_valid = 1'b1; g_upd_index = 4'd0; g_upd_taken = 1'b1; g_upd_predicted = 1'b0;
    tick();
    g_reset = 1'b0;
    idle_g();
    g_dec_branch = 1'b1; g_dec_pc = 32'h10;
    @(negedge clk);
    chk("gs_rst_index", {28'd0, g_pred_index}, 32'd4);
    chk("gs_rst_lookups", {30'd0, g_perf_lookups}, 32'd0);
    chk("gs_rst_mispred", {30'd0, g_perf_mispred}, 32'd0);
    g_dec_pc = 32'h0;
    #1;
    chk("gs_rst_idx0_taken", {31'd0, g_pred_taken}, 32'd0);
    tick();
    idle_g();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
